// File: rtl/hub75_pkg.sv
// hub75_pkg
//   Shared definitions for the HUB75 BCM scheduler:
//   - one-hot FSM state encodings and the state enum built from them
//   - HUB75 connector pin-order constants (bit positions in a packed pin bus)
//   - width helper used to size the on-period timer
//   Optional feature macro: HUB75_BCM_BRIGHTNESS_EN (uses BRIGHT_W).
package hub75_pkg;

    localparam int ST_W = 6;

    localparam logic [ST_W-1:0] ST_IDLE_OH    = 6'b000001;
    localparam logic [ST_W-1:0] ST_SHIFT_OH   = 6'b000010;
    localparam logic [ST_W-1:0] ST_BLANK_OH   = 6'b000100;
    localparam logic [ST_W-1:0] ST_LATCH_OH   = 6'b001000;
    localparam logic [ST_W-1:0] ST_UNLATCH_OH = 6'b010000;
    localparam logic [ST_W-1:0] ST_UNBLANK_OH = 6'b100000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_IDLE_OH,
        S_SHIFT   = ST_SHIFT_OH,
        S_BLANK   = ST_BLANK_OH,
        S_LATCH   = ST_LATCH_OH,
        S_UNLATCH = ST_UNLATCH_OH,
        S_UNBLANK = ST_UNBLANK_OH
    } state_e;

    // HUB75 connector signal order within a packed pin bus
    localparam int HUB75_PIN_R1  = 0;
    localparam int HUB75_PIN_G1  = 1;
    localparam int HUB75_PIN_B1  = 2;
    localparam int HUB75_PIN_R2  = 3;
    localparam int HUB75_PIN_G2  = 4;
    localparam int HUB75_PIN_B2  = 5;
    localparam int HUB75_PIN_A   = 6;
    localparam int HUB75_PIN_B   = 7;
    localparam int HUB75_PIN_C   = 8;
    localparam int HUB75_PIN_D   = 9;
    localparam int HUB75_PIN_E   = 10;
    localparam int HUB75_PIN_CLK = 11;
    localparam int HUB75_PIN_LAT = 12;
    localparam int HUB75_PIN_OE  = 13;

    // brightness is a fraction of 256
    localparam int BRIGHT_W = 8;

    function automatic int hub75_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// hub75_on_timer
//   Loadable down-counter timing one bitplane's on-period.
//   Ports:
//     clk, reset_n    clock, synchronous active-low reset
//     load, load_val  load the full plane period (cycles)
//     brightness      [HUB75_BCM_BRIGHTNESS_EN only] fraction of the period lit
//     timer_zero      full plane period has elapsed
//     lit_expire      1-cycle pulse: last lit cycle, panel must go dark next
//     lit_empty       combinational: the value being loaded gives no lit time
//   Optional feature macro: HUB75_BCM_BRIGHTNESS_EN adds a second counter that
//   ends the lit window at (period*(brightness+1))>>8 while the period runs on.
module hub75_on_timer
    import hub75_pkg::*;
#(
    parameter int TMR_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
`ifdef HUB75_BCM_BRIGHTNESS_EN
    input  logic [7:0]       brightness,
`endif
    output logic             timer_zero,
    output logic             lit_expire,
    output logic             lit_empty
);

    logic [TMR_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_zero = (timer_q == '0);

`ifdef HUB75_BCM_BRIGHTNESS_EN
    // period * 256 always fits in TMR_W+8 bits because period <= 2**(TMR_W-1)
    logic [BRIGHT_W:0]         lit_mul;
    logic [TMR_W+BRIGHT_W-1:0] lit_prod;
    logic [TMR_W-1:0]          lit_len;
    logic [TMR_W-1:0]          lit_q, lit_d;

    assign lit_mul  = {1'b0, brightness} + 9'd1;
    assign lit_prod = {{BRIGHT_W{1'b0}}, load_val} * {{(TMR_W-1){1'b0}}, lit_mul};
    assign lit_len  = TMR_W'(lit_prod >> BRIGHT_W);

    always_comb begin
        lit_d = lit_q;
        if (load) begin
            lit_d = lit_len;
        end else if (lit_q != '0) begin
            lit_d = lit_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lit_q <= '0;
        end else begin
            lit_q <= lit_d;
        end
    end

    assign lit_expire = (lit_q == TMR_W'(1));
    assign lit_empty  = (lit_len == '0);
`else
    assign lit_expire = (timer_q == TMR_W'(1));
    assign lit_empty  = (load_val == '0);
`endif

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler
//   Sequences one HUB75 panel for BCM greyscale: rows outer, bitplanes inner
//   (LSB first). Each plane is lit for BASE_ON<<plane cycles while the shifter
//   loads the next row/plane in the background.
//   Ports:
//     clk, reset_n            clk30, synchronous active-low reset
//     run                     enable, sampled only at a row/plane boundary
//     brightness              [HUB75_BCM_BRIGHTNESS_EN only] lit fraction /256
//     shift_req/_row/_plane   request to the shifter, held until shift_done
//     shift_done              1-cycle completion pulse from the shifter
//     led_addr/blank/latch    panel address, OE (1 = dark), LAT
//     frame_start             pulse when row 0 / plane 0 is latched
//     frame_count             completed frames, wraps
//   Optional feature macro: HUB75_BCM_BRIGHTNESS_EN.
//
//   state     | meaning
//   S_IDLE    | stopped; on-timer may still be running out
//   S_SHIFT   | shift requested; wait for shift_done and end of on-period
//   S_BLANK   | panel dark, row address updated
//   S_LATCH   | LAT high, shifted data moves to output drivers
//   S_UNLATCH | LAT low
//   S_UNBLANK | panel lit, on-timer loaded, advance to next plane/row
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int ROW_BITS = 5,
    parameter int PLANES   = 8,
    parameter int BASE_ON  = 4,
    parameter int TMR_W    = hub75_clog2(BASE_ON << (PLANES - 1)) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
`ifdef HUB75_BCM_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    output logic                shift_req,
    output logic [ROW_BITS-1:0] shift_row,
    output logic [2:0]          shift_plane,
    input  logic                shift_done,
    output logic [ROW_BITS-1:0] led_addr,
    output logic                led_blank,
    output logic                led_latch,
    output logic                frame_start,
    output logic [15:0]         frame_count
);

    localparam logic [2:0]          PLANE_LAST = 3'(PLANES - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST   = {ROW_BITS{1'b1}};

    state_e              state_q, state_d;
    logic                done_seen_q, done_seen_d;
    logic [ROW_BITS-1:0] shift_row_q, shift_row_d;
    logic [2:0]          shift_plane_q, shift_plane_d;
    logic [2:0]          latched_plane_q, latched_plane_d;
    logic [ROW_BITS-1:0] led_addr_q, led_addr_d;
    logic                led_blank_q, led_blank_d;
    logic                led_latch_q, led_latch_d;
    logic                frame_start_q, frame_start_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_zero;
    logic                lit_expire;
    logic                lit_empty;

    assign tmr_load_val = TMR_W'(BASE_ON) << latched_plane_q;

    hub75_on_timer #(
        .TMR_W (TMR_W)
    ) u_on_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_val   (tmr_load_val),
`ifdef HUB75_BCM_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .timer_zero (tmr_zero),
        .lit_expire (lit_expire),
        .lit_empty  (lit_empty)
    );

    always_comb begin
        state_d         = state_q;
        done_seen_d     = 1'b0;
        shift_row_d     = shift_row_q;
        shift_plane_d   = shift_plane_q;
        latched_plane_d = latched_plane_q;
        led_addr_d      = led_addr_q;
        led_blank_d     = led_blank_q;
        led_latch_d     = led_latch_q;
        frame_start_d   = 1'b0;
        frame_count_d   = frame_count_q;
        tmr_load        = 1'b0;

        // end of lit window goes dark regardless of state, including S_IDLE
        if (lit_expire) begin
            led_blank_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // done may arrive long before the on-period ends; remember it
                done_seen_d = done_seen_q | shift_done;
                if ((done_seen_q || shift_done) && tmr_zero) begin
                    done_seen_d = 1'b0;
                    state_d     = S_BLANK;
                end
            end
            S_BLANK: begin
                led_blank_d = 1'b1;
                led_addr_d  = shift_row_q;
                state_d     = S_LATCH;
            end
            S_LATCH: begin
                led_latch_d     = 1'b1;
                latched_plane_d = shift_plane_q;
                frame_start_d   = (shift_row_q == '0) && (shift_plane_q == 3'd0);
                state_d         = S_UNLATCH;
            end
            S_UNLATCH: begin
                led_latch_d = 1'b0;
                state_d     = S_UNBLANK;
            end
            S_UNBLANK: begin
                led_blank_d = lit_empty;
                tmr_load    = 1'b1;
                if (shift_plane_q == PLANE_LAST) begin
                    shift_plane_d = 3'd0;
                    shift_row_d   = shift_row_q + ROW_BITS'(1);
                    if (shift_row_q == ROW_LAST) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end else begin
                    shift_plane_d = shift_plane_q + 3'd1;
                end
                state_d = run ? S_SHIFT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            done_seen_q     <= 1'b0;
            shift_row_q     <= '0;
            shift_plane_q   <= 3'd0;
            latched_plane_q <= 3'd0;
            led_addr_q      <= '0;
            led_blank_q     <= 1'b1;
            led_latch_q     <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_count_q   <= 16'd0;
        end else begin
            state_q         <= state_d;
            done_seen_q     <= done_seen_d;
            shift_row_q     <= shift_row_d;
            shift_plane_q   <= shift_plane_d;
            latched_plane_q <= latched_plane_d;
            led_addr_q      <= led_addr_d;
            led_blank_q     <= led_blank_d;
            led_latch_q     <= led_latch_d;
            frame_start_q   <= frame_start_d;
            frame_count_q   <= frame_count_d;
        end
    end

    // request drops the cycle after shift_done is captured
    assign shift_req   = (state_q == S_SHIFT) && !done_seen_q;
    assign shift_row   = shift_row_q;
    assign shift_plane = shift_plane_q;
    assign led_addr    = led_addr_q;
    assign led_blank   = led_blank_q;
    assign led_latch   = led_latch_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// tb_hub75_bcm_scheduler
//   Drives hub75_bcm_scheduler as a shifter with random response delays and
//   predicts every pin from a plane timeline: a plane whose request rises at
//   cycle r with shift_done at D = r+d proceeds at P = max(D, end of previous
//   on-period); latch is high at P+3, the panel lights at P+5 for BASE_ON<<plane
//   cycles and the next request rises at P+5.
//   Optional feature macro: HUB75_BCM_BRIGHTNESS_EN.
`timescale 1ns/1ps
module tb_hub75_bcm_scheduler;

    localparam int ROW_BITS = 5;
    localparam int PLANES   = 8;
    localparam int BASE_ON  = 4;
    localparam int ROWS     = 1 << ROW_BITS;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                run = 1'b0;
    logic                shift_done = 1'b0;
    logic                shift_req;
    logic [ROW_BITS-1:0] shift_row;
    logic [2:0]          shift_plane;
    logic [ROW_BITS-1:0] led_addr;
    logic                led_blank;
    logic                led_latch;
    logic                frame_start;
    logic [15:0]         frame_count;
`ifdef HUB75_BCM_BRIGHTNESS_EN
    logic [7:0]          brightness = 8'd255;
`endif

    hub75_bcm_scheduler #(
        .ROW_BITS (ROW_BITS),
        .PLANES   (PLANES),
        .BASE_ON  (BASE_ON)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
`ifdef HUB75_BCM_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .shift_req   (shift_req),
        .shift_row   (shift_row),
        .shift_plane (shift_plane),
        .shift_done  (shift_done),
        .led_addr    (led_addr),
        .led_blank   (led_blank),
        .led_latch   (led_latch),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // model of the running on-period
    int tz = 0;
    int lit_end = 0;
    bit lit_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lit();
        if (lit_valid && cyc == lit_end - 1) check_val("lit_low", led_blank, 0);
        if (lit_valid && cyc == lit_end) begin
            check_val("lit_end_dark", led_blank, 1);
            lit_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_vals();
        check_val("rst_blank", led_blank, 1);
        check_val("rst_latch", led_latch, 0);
        check_val("rst_addr", led_addr, 0);
        check_val("rst_req", shift_req, 0);
        check_val("rst_row", shift_row, 0);
        check_val("rst_plane", shift_plane, 0);
        check_val("rst_fstart", frame_start, 0);
        check_val("rst_fcount", frame_count, 0);
    endtask

    // Called at the cycle the request for plane index n is expected to be high.
    task automatic do_plane(input int n, input int d, input bit keep_run);
        int r, dc, p, row, pl, nlit;
`ifdef HUB75_BCM_BRIGHTNESS_EN
        int b;
        b = 255;
`endif
        r   = cyc;
        dc  = r + d;
        p   = (dc > tz) ? dc : tz;
        row = (n / PLANES) % ROWS;
        pl  = n % PLANES;
        check_val("req_rise", shift_req, 1);
        check_val("req_row", shift_row, row);
        check_val("req_plane", shift_plane, pl);
        while (cyc < p + 5) begin
            chk_lit();
            shift_done = (cyc == dc);
            if (cyc == p + 4) begin
                run = keep_run;
`ifdef HUB75_BCM_BRIGHTNESS_EN
                if (pl == 7) b = 127;
                else if (pl == 0 && row == 0) b = 0;
                else b = $urandom_range(0, 255);
                brightness = 8'(b);
`endif
            end
            if (cyc == dc) begin
                check_val("req_held", shift_req, 1);
                check_val("row_stable", shift_row, row);
                check_val("plane_stable", shift_plane, pl);
            end
            if (cyc == dc + 1) check_val("req_drop", shift_req, 0);
            if (cyc == p + 2) begin
                check_val("latch_pre", led_latch, 0);
                check_val("addr", led_addr, row);
                check_val("blank_at_latch", led_blank, 1);
            end
            if (cyc == p + 3) begin
                check_val("latch_pulse", led_latch, 1);
                check_val("latch_addr", led_addr, row);
                check_val("frame_start", frame_start, (row == 0 && pl == 0) ? 1 : 0);
            end
            if (cyc == p + 4) begin
                check_val("latch_end", led_latch, 0);
                check_val("frame_start_end", frame_start, 0);
            end
            tick();
        end
        shift_done = 1'b0;
`ifdef HUB75_BCM_BRIGHTNESS_EN
        nlit = ((BASE_ON << pl) * (b + 1)) >> 8;
`else
        nlit = BASE_ON << pl;
`endif
        check_val("unblank", led_blank, (nlit == 0) ? 1 : 0);
        check_val("next_req", shift_req, keep_run ? 1 : 0);
        check_val("frame_count", frame_count, ((n + 1) / (ROWS * PLANES)) % 65536);
        tz        = cyc + (BASE_ON << pl);
        lit_end   = cyc + nlit;
        lit_valid = (nlit != 0);
    endtask

    function automatic int pick_delay(input int n);
        if (n == 0) return 10;
        if (n == 8) return 100;
        if ($urandom_range(0, 9) == 0) return $urandom_range(1, 40);
        return $urandom_range(1, 3);
    endfunction

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        run     = 1'b1;
        chk_reset_vals();
        tick();
        tz = 0;
        lit_valid = 1'b0;

        // one full frame plus most of the first row of the next
        for (int n = 0; n < 262; n++) begin
            do_plane(n, pick_delay(n), 1'b1);
        end

        // stop at a boundary: timer keeps running and darkens the panel in idle
        do_plane(262, 2, 1'b0);
        for (int i = 0; i < 300; i++) begin
            chk_lit();
            check_val("idle_req", shift_req, 0);
            tick();
        end
        run = 1'b1;
        tick();
        do_plane(263, 1, 1'b1);

        // request for row 1 / plane 0 pending, plane 7 still lit
        tick();
        tick();
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        check_val("done_wait_timer", shift_req, 0);
        tick();
        reset_n    = 1'b0;
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        lit_valid  = 1'b0;
        chk_reset_vals();
        reset_n = 1'b1;
        run     = 1'b0;
        tick();
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("stray_req", shift_req, 0);
            check_val("stray_blank", led_blank, 1);
            tick();
        end
        run = 1'b1;
        tick();
        tz = 0;
        do_plane(0, 10, 1'b1);
        do_plane(1, 1, 1'b1);
        do_plane(2, 6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: cycle %0d got timeout expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hub75_bcm_scheduler.md
Name: hub75_bcm_scheduler

Overview:
- Sequences one HUB75 panel for binary-code-modulated (BCM) greyscale.
- Walks rows (outer loop) and bitplanes (inner loop, LSB first).
- Requests a row/plane shift from the pixel shifter via a req/done handshake.
- Drives blank, latch and address pins, and times each plane's on-period at BASE_ON<<plane cycles; the next shift overlaps the current on-period.
- Sits between the clk30 domain top level and the shift/SCLK engine; replaces inline panel sequencing.

Parameters:
- ROW_BITS, 5, address width; rows = 2**ROW_BITS
- PLANES, 8, bitplanes per row, 1..8
- BASE_ON, 4, on-time in cycles of plane 0, >=1
- TMR_W, $clog2(BASE_ON<<(PLANES-1))+1, on-timer width

Ports:
- clk, input, 1, system clock (clk30)
- reset_n, input, 1, reset; synchronous, active-low
- run, input, 1, enable; sampled only at a row/plane boundary
- shift_req, output, 1, request that the shifter load shift_row/shift_plane
- shift_row, output, ROW_BITS, row being shifted
- shift_plane, output, 3, plane being shifted
- shift_done, input, 1, 1-cycle pulse from the shifter: shift complete
- led_addr, output, ROW_BITS, panel row address
- led_blank, output, 1, panel OE, 1 = dark
- led_latch, output, 1, panel LAT
- frame_start, output, 1, 1-cycle pulse on latching row 0 / plane 0
- frame_count, output, 16, completed frames, wraps

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - led_blank=1; led_latch=0; led_addr=0; shift_req=0.
  - shift_row=0; shift_plane=0; frame_start=0; frame_count=0.
  - Timer=0; state=S_IDLE.
  - Reset mid-operation aborts any handshake; a late shift_done is ignored.
- States, one-hot:
  - S_IDLE: stays while run=0. When run=1, next state is S_SHIFT.
  - S_SHIFT: shift_req=1.
    - Exits only when shift_done has been seen (sticky flag) AND timer==0; next state is S_BLANK.
    - shift_req drops the cycle after shift_done is sampled.
    - shift_row/shift_plane are stable while shift_req=1.
  - S_BLANK: led_blank=1; led_addr<=shift_row.
  - S_LATCH: led_latch=1; latched plane := shift_plane.
    - Asserts frame_start if shift_row=0 and shift_plane=0.
  - S_UNLATCH: led_latch=0.
  - S_UNBLANK:
    - led_blank=0; timer<=BASE_ON<<latched_plane.
    - Advance shift_plane. On PLANES-1, plane wraps to 0 and shift_row increments (wraps at 2**ROW_BITS-1).
    - If the previous row wrapped, frame_count+1.
    - Next state: S_SHIFT if run=1, else S_IDLE. In S_IDLE the timer still runs and blanks at expiry.
- Timer: decrements each cycle while nonzero, in any state.
  - At the cycle it reaches 0, led_blank<=1 (dark gap).
  - The panel is never lit longer than the programmed on-time.
- Shift slower than the on-time: panel stays blanked until shift_done. On-time stays exact; only the duty cycle drops.
- shift_done arriving while timer>0: recorded; the scheduler waits for the timer.
- shift_done in the same cycle as timer reaching 0: proceed to S_BLANK next cycle.
- First plane after reset: timer=0, so the panel is blanked until the first latch.
- Fixed overhead per plane: 4 cycles (BLANK, LATCH, UNLATCH, UNBLANK).

Optional Feature:
- Macro HUB75_BCM_BRIGHTNESS_EN.
- When defined:
  - Adds input `brightness` [7:0].
  - Keeps the per-plane period BASE_ON<<p.
  - Re-asserts led_blank once elapsed cycles reach ((BASE_ON<<p)*(brightness+1))>>8.
  - A result of 0 means the plane stays dark.
  - brightness is sampled at S_UNBLANK.
- When undefined: no port; on for the full period.

Decomposition:
- Package hub75_pkg:
  - State one-hot localparams.
  - HUB75 pin-order constants.
  - Width functions (clog2 helper).
- One sub-module, hub75_on_timer: loadable down-counter with expiry pulse; optionally holds the brightness compare.

Test Plan:
- Reset then run=1, shifter returns shift_done 10 cycles after req -> first req at (row0, plane0); latch pulse 1 cycle; frame_start=1 at that latch; led_blank low for exactly 4 cycles after plane 0.
- Instant shifter (done 1 cycle after req), BASE_ON=4 -> low-blank widths 4, 8, 16 … 512 for planes 0..7; then row advances to 1.
- Shifter delay 100 cycles on plane 0 -> blank low exactly 4 cycles, then high ~96 cycles until shift_done; LATCH follows 2 cycles later.
- Run a full frame (32 rows x 8 planes) -> frame_count 0→1; shift_row wraps 31→0; second frame_start seen.
- Assert reset_n=0 mid-S_SHIFT with a pending shift_done -> all outputs at reset values next cycle; stray shift_done ignored.
- With HUB75_BCM_BRIGHTNESS_EN, brightness=127 -> plane 7 lit 256 of 512 cycles; brightness=0, plane 0 -> blank never deasserts.
